// File: rtl/neuron_state_mem_if.sv
// Bus bundle for neuron_state_mem: sweep control, status and per-bank read/write ports.
// Bank b occupies slice b of every packed bus.
interface neuron_state_mem_if #(
   parameter int NUM_BANKS     = 2,
   parameter int AW            = 6,
   parameter int VMEM_WIDTH    = 16,
   parameter int REF_CTR_WIDTH = 4
);
   logic                               i_clear;
   logic                               o_ready;
   logic                               o_drop;
   logic [NUM_BANKS-1:0]               i_wr_en;
   logic [NUM_BANKS*AW-1:0]            i_wr_addr;
   logic [NUM_BANKS*VMEM_WIDTH-1:0]    i_vmem_in;
   logic [NUM_BANKS*REF_CTR_WIDTH-1:0] i_ref_ctr_in;
   logic [NUM_BANKS-1:0]               i_rd_en;
   logic [NUM_BANKS*AW-1:0]            i_rd_addr;
   logic [NUM_BANKS*VMEM_WIDTH-1:0]    o_vmem_out;
   logic [NUM_BANKS*REF_CTR_WIDTH-1:0] o_ref_ctr_out;
   logic [NUM_BANKS-1:0]               o_rd_valid;

   modport master (
      output i_clear, i_wr_en, i_wr_addr, i_vmem_in, i_ref_ctr_in, i_rd_en, i_rd_addr,
      input  o_ready, o_drop, o_vmem_out, o_ref_ctr_out, o_rd_valid
   );

   modport slave (
      input  i_clear, i_wr_en, i_wr_addr, i_vmem_in, i_ref_ctr_in, i_rd_en, i_rd_addr,
      output o_ready, o_drop, o_vmem_out, o_ref_ctr_out, o_rd_valid
   );
endinterface

// File: rtl/neuron_state_mem.sv
// Banked LUTRAM neuron state store ({ref_ctr, vmem} per word) with an init sweep after reset/clear.
// Optional macro NEURON_STATE_MEM_WR_BYPASS_EN: same-address same-cycle write/read returns the new word.
module neuron_state_mem #(
   parameter int NUM_NEURONS   = 128,
   parameter int NUM_BANKS     = 2,
   parameter int VMEM_WIDTH    = 16,
   parameter int REF_CTR_WIDTH = 4,
   parameter int VMEM_INIT     = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   neuron_state_mem_if.slave  bus
);
   localparam int DEPTH = NUM_NEURONS / NUM_BANKS;
   localparam int AW    = $clog2(DEPTH);
   localparam int SW    = VMEM_WIDTH + REF_CTR_WIDTH;
   localparam logic [SW-1:0] INIT_WORD = {{REF_CTR_WIDTH{1'b0}}, VMEM_WIDTH'(VMEM_INIT)};

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_cnt;
   logic [AW-1:0]   w_cnt_nxt;
   logic            r_ready;
   logic            r_drop;
   logic            w_run;
   logic            w_any_req;

   logic [VMEM_WIDTH-1:0]    w_vmem_q [NUM_BANKS];
   logic [REF_CTR_WIDTH-1:0] w_ref_q  [NUM_BANKS];
   logic [NUM_BANKS-1:0]     w_valid_q;
   logic [NUM_BANKS*VMEM_WIDTH-1:0]    w_vmem_pack;
   logic [NUM_BANKS*REF_CTR_WIDTH-1:0] w_ref_pack;

   assign w_run     = (r_state == ST_RUN);
   assign w_any_req = (|bus.i_wr_en) || (|bus.i_rd_en);

   // Next-state logic: sweep INIT over all addresses, then RUN until a clear request.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_INIT: begin
            if (bus.i_clear) begin
               w_cnt_nxt = {AW{1'b0}};
            end else if (r_cnt == AW'(DEPTH - 1)) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = {AW{1'b0}};
            end else begin
               w_cnt_nxt = r_cnt + AW'(1);
            end
         end
         ST_RUN: begin
            if (bus.i_clear) begin
               w_state_nxt = ST_INIT;
               w_cnt_nxt   = {AW{1'b0}};
            end else begin
               w_cnt_nxt = r_cnt;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = {AW{1'b0}};
         end
      endcase
   end

   // State, sweep counter and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= {AW{1'b0}};
         r_ready <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_state_nxt == ST_RUN);
         r_drop  <= w_any_req && !r_ready;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      (* ram_style = "distributed" *) logic [SW-1:0] r_mem [DEPTH];

      logic                     w_we;
      logic                     w_re;
      logic [AW-1:0]            w_wa;
      logic [AW-1:0]            w_ra;
      logic [SW-1:0]            w_wd;
      logic [SW-1:0]            w_rd_word;
      logic [VMEM_WIDTH-1:0]    r_vmem;
      logic [REF_CTR_WIDTH-1:0] r_ref;
      logic                     r_valid;

      assign w_we = w_run && bus.i_wr_en[b];
      assign w_re = w_run && bus.i_rd_en[b];
      assign w_wa = bus.i_wr_addr[b*AW +: AW];
      assign w_ra = bus.i_rd_addr[b*AW +: AW];
      assign w_wd = {bus.i_ref_ctr_in[b*REF_CTR_WIDTH +: REF_CTR_WIDTH],
                     bus.i_vmem_in[b*VMEM_WIDTH +: VMEM_WIDTH]};

`ifdef NEURON_STATE_MEM_WR_BYPASS_EN
      assign w_rd_word = (w_we && (w_wa == w_ra)) ? w_wd : r_mem[w_ra];
`else
      assign w_rd_word = r_mem[w_ra];
`endif

      // Storage write port: sweep word while initialising, user word while running.
      always_ff @(posedge clk) begin
         if (!w_run) begin
            r_mem[r_cnt] <= INIT_WORD;
         end else if (w_we) begin
            r_mem[w_wa] <= w_wd;
         end
      end

      // Registered read port; data holds when no read is issued.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vmem  <= {VMEM_WIDTH{1'b0}};
            r_ref   <= {REF_CTR_WIDTH{1'b0}};
            r_valid <= 1'b0;
         end else begin
            r_valid <= w_re;
            if (w_re) begin
               r_vmem <= w_rd_word[VMEM_WIDTH-1:0];
               r_ref  <= w_rd_word[SW-1:VMEM_WIDTH];
            end
         end
      end

      assign w_vmem_q[b]  = r_vmem;
      assign w_ref_q[b]   = r_ref;
      assign w_valid_q[b] = r_valid;
   end

   // Pack per-bank read registers onto the shared output buses.
   always_comb begin
      w_vmem_pack = {(NUM_BANKS*VMEM_WIDTH){1'b0}};
      w_ref_pack  = {(NUM_BANKS*REF_CTR_WIDTH){1'b0}};
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_vmem_pack[b*VMEM_WIDTH +: VMEM_WIDTH]      = w_vmem_q[b];
         w_ref_pack[b*REF_CTR_WIDTH +: REF_CTR_WIDTH] = w_ref_q[b];
      end
   end

   assign bus.o_ready       = r_ready;
   assign bus.o_drop        = r_drop;
   assign bus.o_vmem_out    = w_vmem_pack;
   assign bus.o_ref_ctr_out = w_ref_pack;
   assign bus.o_rd_valid    = w_valid_q;
endmodule

// File: doc/neuron_state_mem.md
# neuron_state_mem

Banked, parametrised neuron state store (Vmem + refractory counter) for the fan-IO TDM core. It is built as distributed RAM. It serves NUM_BANKS processing units in parallel, with one independent write port and one independent read port per bank. It adds a hardware initialisation sweep, so that state is cleared after reset or on request, and an optional write-to-read bypass. It sits between the TDM controller and the neuron processing units.

## Interface
- NUM_NEURONS, 128: total neurons; must be a multiple of NUM_BANKS.
- NUM_BANKS, 2: parallel banks/channels; DEPTH = NUM_NEURONS/NUM_BANKS, power of two, ≥2.
- VMEM_WIDTH, 16: signed Vmem width.
- REF_CTR_WIDTH, 4: refractory counter width.
- VMEM_INIT, 0: signed value written to every Vmem during the sweep.
- Derived: AW = $clog2(DEPTH), SW = VMEM_WIDTH + REF_CTR_WIDTH.

Ports (bank b occupies slice b of every packed bus):
- clk  in  1  clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  request a re-initialisation sweep.
- o_ready  out  1  high when the sweep is complete and memory is accessible.
- o_drop  out  1  one-cycle pulse: a request was discarded while not ready.
- i_wr_en  in  NUM_BANKS  per-bank write enable.
- i_wr_addr  in  NUM_BANKS*AW  per-bank write address.
- i_vmem_in  in  NUM_BANKS*VMEM_WIDTH  write Vmem (signed per slice).
- i_ref_ctr_in  in  NUM_BANKS*REF_CTR_WIDTH  write refractory count.
- i_rd_en  in  NUM_BANKS  per-bank read enable.
- i_rd_addr  in  NUM_BANKS*AW  per-bank read address.
- o_vmem_out  out  NUM_BANKS*VMEM_WIDTH  read Vmem.
- o_ref_ctr_out  out  NUM_BANKS*REF_CTR_WIDTH  read refractory count.
- o_rd_valid  out  NUM_BANKS  read data valid, per bank.

## Operation
- Storage: one `(* ram_style = "distributed" *)` array per bank, DEPTH × SW. Each word is packed as {ref_ctr, vmem}. Array contents are not reset.
- FSM with two states.
  - INIT: sweep counter cnt (AW bits) writes {0, VMEM_INIT} to address cnt in all banks each cycle.
    - cnt = DEPTH-1 → go to RUN.
    - i_clear in INIT → restart cnt = 0.
  - RUN: normal access.
    - i_clear → INIT, cnt = 0.
  - Reset → INIT, cnt = 0.
- o_ready = (state == RUN), registered.
- In INIT, user writes are ignored and no o_rd_valid is issued.
- o_drop asserts the cycle after any i_wr_en or i_rd_en bit is high while o_ready = 0.
- RUN write: i_wr_en[b] writes the packed slice to bank b at i_wr_addr[b].
- RUN read: i_rd_en[b] captures bank b at i_rd_addr[b] into the output register. o_rd_valid[b] = 1 in the next cycle.
- Without i_rd_en[b], the data outputs hold their last value and o_rd_valid[b] = 0.
- The cycle in which i_clear is sampled in RUN still performs that cycle's accesses. From the next cycle the block is in INIT.
- Banks are fully independent: no cross-bank conflicts exist.

## Timing
- Reset values: o_ready 0, o_drop 0, o_rd_valid 0, o_vmem_out 0, o_ref_ctr_out 0, FSM INIT, cnt 0.
- Sweep length: DEPTH cycles from the first clk edge after rst_n deasserts. o_ready rises in the cycle after cnt = DEPTH-1 is written.
- Read latency: 1 cycle, address to data/valid. Throughput is one read plus one write per bank per cycle.
- Same-cycle write and read to the same bank and address: result is set by WR_BYPASS_EN (see Configuration).
- Reset asserted mid-sweep or mid-read: outputs are cleared immediately (asynchronously). An in-flight read is lost, and the sweep restarts after release.

## Configuration
- `NEURON_STATE_MEM_WR_BYPASS_EN` defined: a same-address, same-cycle write/read returns the newly written word (write-first). This is implemented with a forwarding mux on the registered read path.
- Undefined: the read returns the word stored before the write (read-first, native LUTRAM behaviour). No forwarding logic is built.

## Test plan
- Reset sweep: release rst_n with defaults. Expect o_ready = 0 for 64 cycles then 1. Read of every address in both banks returns vmem 0, ref 0, with o_rd_valid one cycle later.
- Independent banks: write bank0 addr 5 = {3, -100} and bank1 addr 5 = {7, 1234} in the same cycle. Reading both next cycle returns exactly those values, with no crosstalk.
- Collision: write bank0 addr 9 = 42 (old value 0) and read addr 9 in the same cycle. Expect 42 with the macro defined, 0 without.
- Clear mid-run: populate values, pulse i_clear. Expect o_ready to fall the next cycle, a 64-cycle sweep, then all reads return VMEM_INIT.
- Drop: assert i_wr_en during INIT. Expect an o_drop pulse one cycle later and the target word unchanged after the sweep.
- Async reset mid-read: assert rst_n low between i_rd_en and the next edge. Expect o_rd_valid = 0 and outputs 0 immediately, with no valid pulse after release.
